// File: rtl/score_display_driver_if.sv
// rtl/score_display_driver_if.sv - score inputs and 7-segment display pins of score_display_driver
interface score_display_driver_if;
    logic       dis_score;
    logic       goal;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output dis_score, goal, score0, score1,
        input  an, seg, dp
    );

    modport slave (
        input  dis_score, goal, score0, score1,
        output an, seg, dp
    );
endinterface

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 4-digit multiplexed score display with frame latch; GOAL_FLASH_EN adds goal flashing
module score_display_driver #(
    parameter int REFRESH_DIV   = 100000,
    parameter int FLASH_HALF    = 25000000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    score_display_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    sh0;
    logic [3:0]    sh1;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          flash_blank;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h3F;
        endcase
    endfunction

    // Scores are sampled only at the end of slot 3 so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
            sh0 <= 4'd0;
            sh1 <= 4'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                sh0 <= bus.score0;
                sh1 <= bus.score1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
        end else if (!bus.dis_score || flash_blank) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
        end else begin
            case (idx)
                2'd0: begin
                    an_q  <= 4'b1110;
                    seg_q <= enc(sh0);
                end
                2'd1: begin
                    if (sh1 == 4'd0) begin
                        an_q  <= 4'b1111;
                        seg_q <= 7'h7F;
                    end else begin
                        an_q  <= 4'b1101;
                        seg_q <= enc(sh1);
                    end
                end
                default: begin
                    an_q  <= 4'b1111;
                    seg_q <= 7'h7F;
                end
            endcase
        end
    end

`ifdef GOAL_FLASH_EN
    localparam int HW = $clog2(FLASH_HALF + 1);
    localparam int TW = $clog2(FLASH_TOGGLES + 1);
    localparam logic [HW-1:0] HALF_MAX = HW'(FLASH_HALF - 1);
    localparam logic [TW-1:0] TOG_INIT = TW'(FLASH_TOGGLES);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} flash_t;

    flash_t        fstate;
    logic          goal_q;
    logic [HW-1:0] hcnt;
    logic [TW-1:0] remain;
    logic          rise;

    assign rise = bus.goal & ~goal_q & bus.dis_score;

    // A new goal restarts the whole flash sequence, even mid-flash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate <= IDLE;
            goal_q <= 1'b0;
            hcnt   <= '0;
            remain <= '0;
        end else begin
            goal_q <= bus.goal;
            if (!bus.dis_score) begin
                fstate <= IDLE;
                hcnt   <= '0;
            end else if (rise) begin
                fstate <= BLANK;
                hcnt   <= '0;
                remain <= TOG_INIT;
            end else if (fstate != IDLE) begin
                if (hcnt == HALF_MAX) begin
                    hcnt   <= '0;
                    remain <= remain - 1'b1;
                    if (remain == TW'(1))
                        fstate <= IDLE;
                    else
                        fstate <= (fstate == BLANK) ? SHOW : BLANK;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    assign flash_blank = (fstate == BLANK);
`else
    logic unused_goal;
    assign unused_goal = bus.goal;
    assign flash_blank = 1'b0;
`endif

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;
endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - directed bench for score_display_driver (REFRESH_DIV=4, FLASH_HALF=8, FLASH_TOGGLES=4)
module tb_score_display_driver;
    logic clk;
    logic rst_n;
    score_display_driver_if sif();

    score_display_driver #(
        .REFRESH_DIV  (4),
        .FLASH_HALF   (8),
        .FLASH_TOGGLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s0;
        logic [3:0] s1;
        logic       dis;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic [3:0] an1;
        logic [6:0] seg1;
    } vec_t;

    vec_t vecs[7];
    int checks   = 0;
    int failures = 0;
    int e        = 0;
    int fstart   = -1;
    logic gprev  = 1'b0;
    logic dis_e  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s e=%0d actual=%h expected=%h", name, e, act, exp);
        end
    endtask

    // One clock edge; records what the DUT sampled so the expectation can follow it.
    task automatic tick();
        logic g_s, d_s;
        g_s = sif.goal;
        d_s = sif.dis_score;
        @(posedge clk);
        e++;
        if (g_s && !gprev && d_s) fstart = e;
        gprev = g_s;
        dis_e = d_s;
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < 16 && (e % 16) != 0; i++) tick();
    endtask

    function automatic logic flash_blank_exp();
`ifdef GOAL_FLASH_EN
        int d;
        d = e - fstart;
        return (fstart > 0) && ((d >= 1 && d <= 8) || (d >= 17 && d <= 24));
`else
        return 1'b0;
`endif
    endfunction

    // Expected output while score 3 / 7 is latched.
    task automatic check_norm(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        int slot;
        slot = ((e - 1) / 4) % 4;
        ea = 4'b1111;
        es = 7'h7F;
        if (dis_e && !flash_blank_exp()) begin
            if (slot == 0) begin ea = 4'b1110; es = 7'h30; end
            else if (slot == 1) begin ea = 4'b1101; es = 7'h78; end
        end
        chk({tag, "_an"}, 32'(sif.an), 32'(ea));
        chk({tag, "_seg"}, 32'(sif.seg), 32'(es));
    endtask

    task automatic reset_at(input int ph);
        for (int i = 0; i < 16 && (e % 16) != ph; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(sif.an), 32'hF);
        chk("async_rst_seg", 32'(sif.seg), 32'h7F);
        @(negedge clk);
        rst_n  = 1'b1;
        e      = 0;
        gprev  = 1'b0;
        fstart = -1;
        dis_e  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'h3, 4'h7, 1'b1, 4'hE, 7'h30, 4'hD, 7'h78};
        vecs[1] = '{4'h5, 4'h0, 1'b1, 4'hE, 7'h12, 4'hF, 7'h7F};
        vecs[2] = '{4'hC, 4'h0, 1'b1, 4'hE, 7'h3F, 4'hF, 7'h7F};
        vecs[3] = '{4'h9, 4'hA, 1'b1, 4'hE, 7'h10, 4'hD, 7'h3F};
        vecs[4] = '{4'h8, 4'h1, 1'b1, 4'hE, 7'h00, 4'hD, 7'h79};
        vecs[5] = '{4'h4, 4'h6, 1'b0, 4'hF, 7'h7F, 4'hF, 7'h7F};
        vecs[6] = '{4'h0, 4'h2, 1'b1, 4'hE, 7'h40, 4'hD, 7'h24};

        rst_n         = 1'b0;
        sif.dis_score = 1'b1;
        sif.goal      = 1'b0;
        sif.score0    = 4'h0;
        sif.score1    = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_an", 32'(sif.an), 32'hF);
        chk("reset_seg", 32'(sif.seg), 32'h7F);
        chk("reset_dp", 32'(sif.dp), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        e     = 0;

        for (int v = 0; v < 7; v++) begin
            align();
            sif.score0    = vecs[v].s0;
            sif.score1    = vecs[v].s1;
            sif.dis_score = vecs[v].dis;
            repeat (16) tick();
            for (int j = 0; j < 16; j++) begin
                int slot;
                logic [3:0] ea;
                logic [6:0] es;
                tick();
                slot = ((e - 1) / 4) % 4;
                ea = (slot == 0) ? vecs[v].an0 : (slot == 1) ? vecs[v].an1 : 4'hF;
                es = (slot == 0) ? vecs[v].seg0 : (slot == 1) ? vecs[v].seg1 : 7'h7F;
                chk($sformatf("vec%0d_an", v), 32'(sif.an), 32'(ea));
                chk($sformatf("vec%0d_seg", v), 32'(sif.seg), 32'(es));
            end
        end
        chk("dp_const", 32'(sif.dp), 32'h1);

        // Mid-frame score change waits for the next frame boundary.
        align();
        sif.score0 = 4'h2;
        sif.score1 = 4'h7;
        repeat (16) tick();
        tick();
        chk("latch_old_seg", 32'(sif.seg), 32'h24);
        tick();
        sif.score0 = 4'h6;
        tick();
        chk("latch_hold_seg_a", 32'(sif.seg), 32'h24);
        tick();
        chk("latch_hold_seg_b", 32'(sif.seg), 32'h24);
        align();
        tick();
        chk("latch_new_an", 32'(sif.an), 32'hE);
        chk("latch_new_seg", 32'(sif.seg), 32'h02);

        // Display disable mid-slot: counters keep running underneath.
        sif.score0 = 4'h3;
        align();
        repeat (16) tick();
        tick();
        check_norm("dis_pre");
        sif.dis_score = 1'b0;
        tick();
        check_norm("dis_off_a");
        tick();
        check_norm("dis_off_b");
        sif.dis_score = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_norm("dis_resume");
        end

        // Asynchronous reset mid-scan, in slot 2 then in slot 0.
        reset_at(10);
        tick();
        reset_at(2);
        for (int i = 0; i < 32; i++) begin
            tick();
            if (e <= 16) begin
                chk("post_rst_an", 32'(sif.an), (e <= 4) ? 32'hE : 32'hF);
                chk("post_rst_seg", 32'(sif.seg), (e <= 4) ? 32'h40 : 32'h7F);
            end else begin
                check_norm("post_rst_frame");
            end
        end

        // Goal flashing: single pulse, restart during SHOW, held level, goal while disabled.
        align();
        sif.goal = 1'b1;
        tick();
        check_norm("flash1");
        sif.goal = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_norm("flash1");
        end
        sif.goal = 1'b1;
        tick();
        sif.goal = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_norm("flash2a");
        end
        sif.goal = 1'b1;
        tick();
        sif.goal = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_norm("flash2b");
        end
        sif.goal = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_norm("flash_held");
        end
        sif.goal = 1'b0;
        tick();
        sif.dis_score = 1'b0;
        sif.goal      = 1'b1;
        tick();
        sif.goal = 1'b0;
        tick();
        sif.dis_score = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check_norm("flash_dis");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
